// File: rtl/lsu_initiator_if.sv
// Request, response and word-memory port bundle for lsu_initiator.
// The slave modport is the LSU itself; the master modport is its environment.
interface lsu_initiator_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_mode;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_mode, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_mode, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_initiator.sv
// Byte-addressed load/store initiator on a word-wide memory port (RMW for sub-word stores).
// Define LSU_MISALIGN_EN to split word-crossing accesses; otherwise misaligned accesses are rejected.
module lsu_initiator #(
    parameter int ADDR_W = 9
) (
    input  logic           clk,
    input  logic           reset,
    lsu_initiator_if.slave bus
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

    state_t            state;

    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              st_we;
    logic [2:0]        st_mode;
    logic [31:0]       st_wdata;
    logic [ADDR_W-1:0] st_w0;
    logic [1:0]        st_off;
    logic [2:0]        st_size;
    logic              st_span;
    logic [31:0]       buf0;
    logic [31:0]       buf1;

    logic [2:0]        in_size;
    logic [1:0]        in_off;
    logic [ADDR_W-1:0] in_w0;
    logic              in_span;
    logic              mode_ok;
    logic              misalign_err;
    logic              in_err;

    logic [63:0]       cur64;
    logic [63:0]       merged;
    logic [31:0]       shifted;
    logic [31:0]       load_data;

    always_comb begin
        in_off  = bus.req_addr[1:0];
        in_w0   = bus.req_addr[ADDR_W+1:2];
        case (bus.req_mode[1:0])
            2'b00:   in_size = 3'd1;
            2'b01:   in_size = 3'd2;
            default: in_size = 3'd4;
        endcase
        mode_ok = (bus.req_mode == 3'b000) || (bus.req_mode == 3'b001) ||
                  (bus.req_mode == 3'b010) || (bus.req_mode == 3'b100) ||
                  (bus.req_mode == 3'b101);
        in_span = ({1'b0, in_off} + in_size) > 3'd4;
`ifdef LSU_MISALIGN_EN
        misalign_err = 1'b0;
`else
        misalign_err = ((in_size == 3'd2) && in_off[0]) ||
                       ((in_size == 3'd4) && (in_off != 2'd0));
`endif
        in_err = !mode_ok
              || (bus.req_we && bus.req_mode[2])
              || (bus.req_addr[31:ADDR_W+2] != '0)
              || (in_span && (in_w0 == '1))
              || misalign_err;
    end

    // Read data is used in the same cycle it arrives, so the byte window is
    // built from the live memory word while still in a read state.
    always_comb begin
        case (state)
            RD0:     cur64 = {buf1, bus.mem_rdata};
            RD1:     cur64 = {bus.mem_rdata, buf0};
            default: cur64 = {buf1, buf0};
        endcase
        merged = cur64;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i >= 32'(st_off) && i < 32'(st_off) + 32'(st_size))
                merged[8*i +: 8] = st_wdata[8*(i - 32'(st_off)) +: 8];
        end
        shifted = 32'(cur64 >> {st_off, 3'b000});
        case (st_mode)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            st_we        <= 1'b0;
            st_mode      <= '0;
            st_wdata     <= '0;
            st_w0        <= '0;
            st_off       <= '0;
            st_size      <= '0;
            st_span      <= 1'b0;
            buf0         <= '0;
            buf1         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!req_ready_q) begin
                        req_ready_q <= 1'b1;
                    end else if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        st_we       <= bus.req_we;
                        st_mode     <= bus.req_mode;
                        st_wdata    <= bus.req_wdata;
                        st_w0       <= in_w0;
                        st_off      <= in_off;
                        st_size     <= in_size;
                        st_span     <= in_span;
                        if (in_err) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_valid_q <= 1'b1;
                            state        <= RESP;
                        end else if (bus.req_we && in_size == 3'd4 && in_off == 2'd0) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= in_w0;
                            mem_wdata_q <= bus.req_wdata;
                            state       <= WR0;
                        end else begin
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= in_w0;
                            state      <= RD0;
                        end
                    end
                end
                RD0: begin
                    buf0 <= bus.mem_rdata;
                    if (st_span) begin
                        mem_addr_q <= st_w0 + 1'b1;
                        state      <= RD1;
                    end else if (st_we) begin
                        mem_re_q    <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged[31:0];
                        state       <= WR0;
                    end else begin
                        mem_re_q     <= 1'b0;
                        resp_rdata_q <= load_data;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                RD1: begin
                    buf1     <= bus.mem_rdata;
                    mem_re_q <= 1'b0;
                    if (st_we) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= st_w0;
                        mem_wdata_q <= merged[31:0];
                        state       <= WR0;
                    end else begin
                        resp_rdata_q <= load_data;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                WR0: begin
                    if (st_span) begin
                        mem_addr_q  <= st_w0 + 1'b1;
                        mem_wdata_q <= merged[63:32];
                        state       <= WR1;
                    end else begin
                        mem_we_q     <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                WR1: begin
                    mem_we_q     <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
- Load/store initiator between the core's execute stage and the word-organised data memory port.
- Accepts byte-addressed load/store requests using the RISC-V funct3 size codes. Turns each request into a sequence of word-wide read/write cycles on the memory port.
- Sub-word stores are done by read-modify-write on the correct little-endian byte lane. Loads are sign/zero-extended.
- Returns one response per request over a valid/ready handshake.

Parameters:
- ADDR_W, 9, word-address width of the memory port. Byte address space is 2^(ADDR_W+2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bytes used.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid & resp_ready.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected with no memory access.
- mem_re  out  1  memory read strobe; mem_rdata is valid in the same cycle.
- mem_we  out  1  memory write strobe; word committed at next rising edge.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data.

Behaviour:
- Reset values: req_ready=0 during reset, then 1 in IDLE. All other outputs 0. State = IDLE.
- The FSM has six states: IDLE, RD0, RD1, WR0, WR1, RESP.
- Latched fields at acceptance: the request fields, plus:
  - w0 = addr[ADDR_W+1:2]
  - off = addr[1:0]
  - size = 1, 2 or 4 bytes
  - span = (off + size > 4)
- IDLE:
  - req_ready=1.
  - On handshake, check for errors first.
  - Error when: mode is not one of the five codes; store with mode 100/101; addr[31:ADDR_W+2] != 0; or span with w0 = all-ones (no wrap).
  - On error → RESP with resp_err=1 and no mem strobes.
  - Otherwise: aligned word store (off=0, W) → WR0; any other request → RD0.
- RD0:
  - mem_re=1, mem_addr=w0; capture mem_rdata into buf0.
  - Next state: span → RD1; else store → WR0; else → RESP.
- RD1:
  - mem_re=1, mem_addr=w0+1; capture into buf1.
  - Next state: store → WR0; load → RESP.
- WR0:
  - mem_we=1, mem_addr=w0.
  - mem_wdata = buf0 with bytes off..min(3, off+size-1) replaced by the low store bytes. The full req_wdata is written for an aligned W.
  - Next state: span → WR1; else → RESP.
- WR1:
  - mem_we=1, mem_addr=w0+1.
  - mem_wdata = buf1 with bytes 0..(off+size-5) replaced by the remaining store bytes.
  - Next state: → RESP.
- Load data assembly:
  - Take the byte stream {buf1,buf0} >> (8*off), low size bytes.
  - Modes 000/001 sign-extend; 100/101 zero-extend.
- RESP:
  - resp_valid=1 with resp_rdata/resp_err stable; req_ready=0.
  - Hold until resp_ready, then → IDLE. The handshake cycle itself does not accept a new request.
- Latency, request accept → resp_valid:
  - aligned load: 2 cycles
  - spanning load: 3
  - aligned W store: 2
  - aligned B/H store: 3
  - spanning store: 5
  - error: 1
- At most one mem strobe per cycle; mem_re and mem_we are never both high.
- Reset mid-operation: return to IDLE immediately. mem_we drops asynchronously; a write whose WR cycle is cut by reset is not committed. For a spanning store interrupted between WR0 and WR1, the first word may already be committed; this is accepted.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro LSU_MISALIGN_EN.
- When defined: spanning accesses are split as above.
- When undefined:
  - Any access with off not a multiple of size is an error (resp_err=1, 1-cycle latency, no strobes).
  - RD1/WR1 are never entered and may be omitted from the RTL.

Test Plan:
- Memory word 3 = 0x8899AABB. Load mode 000, addr 0x0E → resp_rdata 0xFFFFFF99, resp_err 0, resp_valid 2 cycles after accept.
- Same word. Load mode 101, addr 0x0C → resp_rdata 0x0000AABB.
- Word 4 = 0x11223344. Store mode 000, addr 0x11, wdata 0xDEADBEEF → one mem_re, then one mem_we with mem_addr 4, mem_wdata 0x1122EF44.
- LSU_MISALIGN_EN defined. Words 5/6 = 0x44332211/0x88776655. Load W at addr 0x16 → reads 5 then 6, resp_rdata 0x66554433. Without the macro → resp_err 1, no strobes.
- Store W at addr 0x7FE (w0 = 511, span) → resp_err 1, no strobes. Load mode 011 → resp_err 1.
- Assert reset during WR0 of a B store → mem_we low immediately, target word unchanged. After release, req_ready=1 and the next load completes normally.
